// File: rtl/complete_queue.sv
// Complete-stage result queue: buffers functional-unit results and broadcasts the oldest
// CDB_WIDTH of them per cycle. Define COMPLETE_QUEUE_STATS_EN to add broadcast/stall counters.
module complete_queue #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int BUF_DEPTH = 8,
    parameter int ROB_BITS  = 5,
    parameter int PHYS_BITS = 6,
    parameter int XLEN      = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_FU-1:0]               fu_valid,
    input  logic [NUM_FU*ROB_BITS-1:0]      fu_rob_id,
    input  logic [NUM_FU*PHYS_BITS-1:0]     fu_dest_reg,
    input  logic [NUM_FU*XLEN-1:0]          fu_result,
    input  logic [NUM_FU*XLEN-1:0]          fu_pc,
    input  logic [NUM_FU*4-1:0]             fu_flags,
    output logic [NUM_FU-1:0]               fu_ready,
    input  logic                            squash,
    input  logic [ROB_BITS-1:0]             squash_younger_than,
    input  logic [ROB_BITS-1:0]             rob_head,
    output logic [CDB_WIDTH-1:0]            cdb_valid,
    output logic [CDB_WIDTH*ROB_BITS-1:0]   cdb_rob_id,
    output logic [CDB_WIDTH*PHYS_BITS-1:0]  cdb_phys_reg,
    output logic [CDB_WIDTH*XLEN-1:0]       cdb_result,
    output logic [CDB_WIDTH*XLEN-1:0]       cdb_pc_plus_4,
    output logic [CDB_WIDTH*4-1:0]          cdb_flags,
    output logic [$clog2(BUF_DEPTH+1)-1:0]  buf_count
`ifdef COMPLETE_QUEUE_STATS_EN
    ,
    output logic [31:0]                     stat_broadcasts,
    output logic [31:0]                     stat_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [XLEN-1:0]  FOUR_C  = {{(XLEN-3){1'b0}}, 3'b100};

    function automatic logic [ROB_BITS-1:0] age_of(input logic [ROB_BITS-1:0] id,
                                                   input logic [ROB_BITS-1:0] head);
        return id - head;
    endfunction

    function automatic logic [CNT_W-1:0] ones_in(input logic [BUF_DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int k = 0; k < BUF_DEPTH; k++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[k]};
        end
        return n;
    endfunction

    logic [BUF_DEPTH-1:0] valid_r;
    logic [ROB_BITS-1:0]  rob_r    [BUF_DEPTH];
    logic [PHYS_BITS-1:0] dest_r   [BUF_DEPTH];
    logic [XLEN-1:0]      result_r [BUF_DEPTH];
    logic [XLEN-1:0]      pcp4_r   [BUF_DEPTH];
    logic [3:0]           flags_r  [BUF_DEPTH];
    logic [CNT_W-1:0]     count_r;

    logic [ROB_BITS-1:0]  sq_age_s;
    logic [ROB_BITS-1:0]  age_s  [BUF_DEPTH];
    logic [CNT_W-1:0]     rank_s [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] kill_s;
    logic [BUF_DEPTH-1:0] sel_s;
    logic [CNT_W-1:0]     pops_s;
    logic [CNT_W-1:0]     free_s;
    logic [NUM_FU-1:0]    drop_s;
    logic [NUM_FU-1:0]    enq_s;
    logic [BUF_DEPTH-1:0] wr_oh_s [NUM_FU];
    logic [BUF_DEPTH-1:0] valid_nxt_s;
    logic [CNT_W-1:0]     count_nxt_s;

    // Entry ages, squash kill mask, and each entry's rank among valid entries (0 = oldest)
    always_comb begin
        sq_age_s = age_of(squash_younger_than, rob_head);
        for (int e = 0; e < BUF_DEPTH; e++) begin
            age_s[e]  = age_of(rob_r[e], rob_head);
            kill_s[e] = squash & valid_r[e] & (age_s[e] > sq_age_s);
        end
        for (int e = 0; e < BUF_DEPTH; e++) begin
            rank_s[e] = {CNT_W{1'b0}};
            for (int o = 0; o < BUF_DEPTH; o++) begin
                rank_s[e] = rank_s[e] + {{(CNT_W-1){1'b0}},
                    valid_r[o] & ((age_s[o] < age_s[e]) | ((age_s[o] == age_s[e]) & (o < e)))};
            end
        end
    end

    // CDB slot s carries the surviving entry of rank s; unused slots stay all-zero
    always_comb begin
        logic hit;
        hit           = 1'b0;
        cdb_valid     = {CDB_WIDTH{1'b0}};
        cdb_rob_id    = {(CDB_WIDTH*ROB_BITS){1'b0}};
        cdb_phys_reg  = {(CDB_WIDTH*PHYS_BITS){1'b0}};
        cdb_result    = {(CDB_WIDTH*XLEN){1'b0}};
        cdb_pc_plus_4 = {(CDB_WIDTH*XLEN){1'b0}};
        cdb_flags     = {(CDB_WIDTH*4){1'b0}};
        sel_s         = {BUF_DEPTH{1'b0}};
        for (int s = 0; s < CDB_WIDTH; s++) begin
            for (int e = 0; e < BUF_DEPTH; e++) begin
                hit = valid_r[e] & ~kill_s[e] & (rank_s[e] == CNT_W'(s));
                cdb_valid[s] = cdb_valid[s] | hit;
                cdb_rob_id[s*ROB_BITS +: ROB_BITS]    = cdb_rob_id[s*ROB_BITS +: ROB_BITS] | (rob_r[e] & {ROB_BITS{hit}});
                cdb_phys_reg[s*PHYS_BITS +: PHYS_BITS] = cdb_phys_reg[s*PHYS_BITS +: PHYS_BITS] | (dest_r[e] & {PHYS_BITS{hit}});
                cdb_result[s*XLEN +: XLEN]            = cdb_result[s*XLEN +: XLEN] | (result_r[e] & {XLEN{hit}});
                cdb_pc_plus_4[s*XLEN +: XLEN]         = cdb_pc_plus_4[s*XLEN +: XLEN] | (pcp4_r[e] & {XLEN{hit}});
                cdb_flags[s*4 +: 4]                   = cdb_flags[s*4 +: 4] | (flags_r[e] & {4{hit}});
                sel_s[e] = sel_s[e] | hit;
            end
        end
        pops_s = ones_in(sel_s);
        free_s = DEPTH_C - count_r + pops_s;
    end

    // Channel admission in priority order; each accepted channel claims the lowest free entry
    always_comb begin
        logic [CNT_W-1:0]     seen;
        logic [BUF_DEPTH-1:0] avail;
        logic                 room;
        logic                 found;
        logic                 pick;
        seen  = {CNT_W{1'b0}};
        avail = ~valid_r | sel_s;
        room  = 1'b0;
        found = 1'b0;
        pick  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            drop_s[i]   = squash & (age_of(fu_rob_id[i*ROB_BITS +: ROB_BITS], rob_head) > sq_age_s);
            room        = seen < free_s;
            fu_ready[i] = drop_s[i] | room;
            enq_s[i]    = fu_valid[i] & ~drop_s[i] & room;
            seen        = seen + {{(CNT_W-1){1'b0}}, fu_valid[i] & ~drop_s[i]};
            found       = 1'b0;
            wr_oh_s[i]  = {BUF_DEPTH{1'b0}};
            for (int e = 0; e < BUF_DEPTH; e++) begin
                pick          = enq_s[i] & avail[e] & ~found;
                wr_oh_s[i][e] = pick;
                found         = found | pick;
                avail[e]      = avail[e] & ~pick;
            end
        end
    end

    // Pop, squash and enqueue all resolve into one next-valid vector
    always_comb begin
        logic wr_any;
        wr_any = 1'b0;
        for (int e = 0; e < BUF_DEPTH; e++) begin
            wr_any = 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_any = wr_any | wr_oh_s[i][e];
            end
            valid_nxt_s[e] = (valid_r[e] & ~sel_s[e] & ~kill_s[e]) | wr_any;
        end
        count_nxt_s = ones_in(valid_nxt_s);
    end

    // Occupancy state
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {BUF_DEPTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set
    always_ff @(posedge clock) begin
        for (int e = 0; e < BUF_DEPTH; e++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (wr_oh_s[i][e]) begin
                    rob_r[e]    <= fu_rob_id[i*ROB_BITS +: ROB_BITS];
                    dest_r[e]   <= fu_dest_reg[i*PHYS_BITS +: PHYS_BITS];
                    result_r[e] <= fu_result[i*XLEN +: XLEN];
                    pcp4_r[e]   <= fu_pc[i*XLEN +: XLEN] + FOUR_C;
                    flags_r[e]  <= fu_flags[i*4 +: 4];
                end
            end
        end
    end

    assign buf_count = count_r;

`ifdef COMPLETE_QUEUE_STATS_EN
    logic [31:0] stat_bc_r;
    logic [31:0] stat_stall_r;
    logic [32:0] bc_sum_s;
    logic        stall_s;

    // Saturating sum of broadcasts and stall detection
    always_comb begin
        bc_sum_s = {1'b0, stat_bc_r} + {{(33-CNT_W){1'b0}}, pops_s};
        stall_s  = |(fu_valid & ~fu_ready);
    end

    // Statistics counters, saturating at all ones
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_bc_r    <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            stat_bc_r <= bc_sum_s[32] ? 32'hFFFF_FFFF : bc_sum_s[31:0];
            if (stall_s && (stat_stall_r != 32'hFFFF_FFFF)) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end
        end
    end

    assign stat_broadcasts   = stat_bc_r;
    assign stat_stall_cycles = stat_stall_r;
`endif

endmodule
